// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles little-endian words from a byte stream; word_ready marks the byte
// that completes a word, with word showing the finished value in that cycle.
module byte_to_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  last_idx,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [31:0] shreg;

    // New bytes enter at the top so the first byte ends up in [7:0].
    assign word       = {byte_data, shreg[31:8]};
    assign word_ready = byte_valid && (idx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            shreg <= 32'd0;
        end else if (clear) begin
            idx   <= 2'd0;
            shreg <= 32'd0;
        end else if (byte_valid) begin
            shreg <= word;
            idx   <= word_ready ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed UART image -> instruction memory writes.
// Optional trailing XOR checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int          IMEM_WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter int          CNT_WIDTH      = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wen,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] word_count,
    output state_t      fsm_state
);

    // Handshake: rx_valid qualifies rx_data for exactly one cycle; there is no
    // back-pressure, and a byte coinciding with load_start is dropped.

    state_t                 state, next_state;
    logic [31:0]            len;
    logic [CNT_WIDTH-1:0]   tcnt;
    logic                   active, byte_valid, word_ready, timeout, last_word;
    logic [31:0]            word;
    logic [1:0]             last_idx;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign active     = (state == LEN) || (state == DATA) || (state == CSUM);
    assign byte_valid = rx_valid && !load_start && ((state == LEN) || (state == DATA));
    assign timeout    = active && !rx_valid && (tcnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign last_word  = wen && (word_count == len);
    assign last_idx   = (state == LEN) ? 2'(LEN_BYTES - 1) : 2'(WORD_BYTES - 1);

    byte_to_word_packer u_packer (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .clear      (load_start),
        .byte_valid (byte_valid),
        .byte_data  (rx_data),
        .last_idx   (last_idx),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LEN: begin
                if (word_ready) begin
                    if (word == 32'd0)                 next_state = DONE;
                    else if (word > 32'(IMEM_WORDS))   next_state = ERR;
                    else                               next_state = DATA;
                end
            end
            // Leave DATA only after the final wen pulse has been issued.
            DATA: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (last_word) next_state = CSUM;
`else
                if (last_word) next_state = DONE;
`endif
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) next_state = (rx_data == csum) ? DONE : ERR;
            end
`endif
            default: ;
        endcase
        if (timeout)    next_state = ERR;
        if (load_start) next_state = LEN;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wen        <= 1'b0;
            w_addr     <= BASE_ADDR;
            w_data     <= 32'd0;
            word_count <= 32'd0;
            len        <= 32'd0;
            tcnt       <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            wen <= 1'b0;
            if (load_start) begin
                word_count <= 32'd0;
                len        <= 32'd0;
                tcnt       <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end else begin
                if (!active || rx_valid) tcnt <= '0;
                else                     tcnt <= tcnt + 1'b1;
                if (state == LEN && word_ready) len <= word;
                if (state == DATA && word_ready) begin
                    wen        <= 1'b1;
                    w_data     <= word;
                    w_addr     <= BASE_ADDR + (word_count << 2);
                    word_count <= word_count + 32'd1;
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (state == DATA && byte_valid) csum <= csum ^ rx_data;
`endif
            end
        end
    end

    // Release the core only in DONE; a restart pulls it back into reset at once.
    assign cpu_hold  = (state != DONE) || load_start;
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);
    assign fsm_state = state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader; checksum cases run only when
// IMEM_BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;
    import imem_boot_pkg::*;

    localparam int          TIMEOUT = 100;
    localparam logic [31:0] BASE    = 32'h0000_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        wen;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [31:0] word_count;
    state_t      fsm_state;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wen_cnt = 0;
    int          wen_base;
    int unsigned next_idx = 0;
    logic [63:0] exp_q[$];
    logic [31:0] rnd_word;

    imem_boot_loader #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load_start (load_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wen        (wen),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .fsm_state  (fsm_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected {addr, data}.
    always @(negedge sys_clk) begin
        if (wen) begin
            wen_cnt++;
            check("wen_in_data", 64'(fsm_state), 64'(DATA));
            if (exp_q.size() == 0) check("wen_unexpected", 64'd1, 64'd0);
            else                   check("wen_addr_data", {w_addr, w_data}, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge sys_clk);
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back({BASE + 32'(4 * next_idx), w});
        next_idx++;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_load(input logic with_byte);
        @(negedge sys_clk);
        load_start = 1'b1;
        rx_valid   = with_byte;
        rx_data    = 8'hFF;
        #1 check("hold_on_start", 64'(cpu_hold), 64'd1);
        @(negedge sys_clk);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        next_idx   = 0;
        wen_base   = wen_cnt;
        check("count_cleared", word_count, 64'd0);
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !load_done && !load_err; i++) @(negedge sys_clk);
    endtask

    initial begin
        #23;
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_addr", w_addr, 64'(BASE));
        check("rst_data", w_data, 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_count", word_count, 64'd0);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        sys_rst_n = 1'b1;

        // Bytes in IDLE are ignored.
        send_byte(8'h01);
        send_byte(8'h02);
        check("idle_state", 64'(fsm_state), 64'(IDLE));
        check("idle_no_wen", 64'(wen_cnt), 64'd0);

        // Three-word image.
        start_load(1'b0);
        send_len(32'd3);
        send_word(32'h0050_0093);
        send_word(32'h0010_0113);
        send_word(32'h0020_81B3);
        wait_end(50);
        check("l3_done", 64'(load_done), 64'd1);
        check("l3_hold", 64'(cpu_hold), 64'd0);
        check("l3_count", word_count, 64'd3);
        check("l3_drained", 64'(exp_q.size()), 64'd0);

        // Empty image.
        start_load(1'b0);
        send_len(32'd0);
        check("l0_done", 64'(load_done), 64'd1);
        check("l0_no_wen", 64'(wen_cnt - wen_base), 64'd0);

        // Oversized image.
        start_load(1'b0);
        send_len(32'd4097);
        check("big_err", 64'(load_err), 64'd1);
        check("big_hold", 64'(cpu_hold), 64'd1);
        check("big_no_wen", 64'(wen_cnt - wen_base), 64'd0);

        // Largest legal length is accepted.
        start_load(1'b0);
        send_len(32'd4096);
        check("max_len_data", 64'(fsm_state), 64'(DATA));

        // Silence after a partial second word.
        start_load(1'b0);
        send_len(32'd2);
        send_word(32'hA5A5_0001);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_end(3 * TIMEOUT);
        check("to_err", 64'(load_err), 64'd1);
        check("to_one_wen", 64'(wen_cnt - wen_base), 64'd1);
        check("to_count", word_count, 64'd1);

        // Abort after five payload bytes; restart byte coinciding with load_start is dropped.
        start_load(1'b0);
        send_len(32'd2);
        send_word(32'hCAFE_F00D);
        send_byte(8'h99);
        start_load(1'b1);
        send_len(32'd1);
        send_word(32'hDEAD_BEEF);
        wait_end(50);
        check("ab_done", 64'(load_done), 64'd1);
        check("ab_one_wen", 64'(wen_cnt - wen_base), 64'd1);
        check("ab_count", word_count, 64'd1);

        // Random five-word image.
        start_load(1'b0);
        send_len(32'd5);
        for (int i = 0; i < 5; i++) begin
            rnd_word = 32'($urandom);
            send_word(rnd_word);
        end
        wait_end(50);
        check("rnd_done", 64'(load_done), 64'd1);
        check("rnd_count", word_count, 64'd5);
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        start_load(1'b0);
        send_len(32'd1);
        send_word(32'h1122_3344);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        wait_end(50);
        check("cs_ok_done", 64'(load_done), 64'd1);
        check("cs_ok_hold", 64'(cpu_hold), 64'd0);

        start_load(1'b0);
        send_len(32'd1);
        send_word(32'h1122_3344);
        send_byte(8'h45);
        wait_end(50);
        check("cs_bad_err", 64'(load_err), 64'd1);
        check("cs_bad_hold", 64'(cpu_hold), 64'd1);
        check("cs_bad_wen", 64'(wen_cnt - wen_base), 64'd1);
`endif

        // Reset in the middle of a load.
        start_load(1'b0);
        send_len(32'd3);
        send_word(32'h0BAD_CAFE);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_state", 64'(fsm_state), 64'(IDLE));
        check("mid_rst_count", word_count, 64'd0);
        check("mid_rst_addr", w_addr, 64'(BASE));
        check("mid_rst_hold", 64'(cpu_hold), 64'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        repeat (5) @(negedge sys_clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the write port of the instruction memory at boot: receives a byte stream from the UART RX path and assembles little-endian 32-bit words.
- Issues one write per word into instruction memory, holding the CPU in reset until the image is complete.
- Sits between the UART receiver and the instruction-memory write port; the fetch read port is untouched.

Parameters:
- IMEM_WORDS, 4096, instruction memory depth in words; largest accepted image.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- TIMEOUT_CYCLES, 1_000_000, maximum sys_clk cycles between bytes while loading.
- CNT_WIDTH, 20, width of the inter-byte timeout counter.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse; begins a new load.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle.
- rx_data  input  8  received byte.
- wen  output  1  instruction memory write enable, one-cycle pulse per word.
- w_addr  output  32  byte address of the write (memory drops bits [1:0]).
- w_data  output  32  assembled instruction word.
- cpu_hold  output  1  keeps the core in reset while high.
- load_done  output  1  high in DONE.
- load_err  output  1  high in ERR.
- word_count  output  32  number of words written in the current load.

Behaviour:
- Reset values (async, sys_rst_n low): state IDLE, wen=0, w_addr=BASE_ADDR, w_data=0, cpu_hold=1, load_done=0, load_err=0, word_count=0, byte index=0, timeout counter=0.
- Frame format: 4-byte little-endian length L (in words), then 4*L payload bytes, each word little-endian (first byte goes to [7:0]).
- IDLE:
  - cpu_hold=1.
  - load_start -> LEN; clears byte index, word_count and the timeout counter.
  - rx_valid is ignored.
- LEN:
  - Collects 4 bytes into the length register.
  - On the 4th byte: L=0 -> DONE; L>IMEM_WORDS -> ERR; otherwise -> DATA.
- DATA:
  - Shifts bytes into the word buffer.
  - On the 4th byte, the next cycle drives wen=1 with w_data = the assembled word and w_addr = BASE_ADDR + 4*word_count. Latency: one cycle from the last rx_valid to wen.
  - word_count increments in the same cycle as the wen pulse.
  - When word_count reaches L -> DONE, or -> CSUM when the optional feature is compiled in.
- DONE: cpu_hold=0, load_done=1; stays here until load_start.
- ERR: cpu_hold=1, load_err=1; stays here until load_start.
- load_start in any state, including mid-load: synchronous abort and restart into LEN; the partial image is discarded; cpu_hold returns to 1 in the same cycle.
- Timeout:
  - In LEN/DATA/CSUM the counter increments each cycle and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES-1 -> ERR. No wen is issued for a partial word.
- rx_valid and load_start in the same cycle: load_start wins; the byte is dropped.
- w_addr never exceeds BASE_ADDR + 4*(IMEM_WORDS-1), because the length check guarantees it.
- wen is never asserted outside DATA.
- Reset asserted mid-load: immediate return to the reset values; memory contents are left as written.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the last payload byte, the FSM enters CSUM and receives one byte.
  - The byte must equal the XOR of all payload bytes (length bytes excluded).
  - Match -> DONE; mismatch -> ERR.
  - Memory is still written, but cpu_hold stays 1.
- Undefined: no CSUM state and no XOR register; the last word goes directly to DONE.

Decomposition:
- Shared package imem_boot_pkg:
  - state encoding constants: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - LEN_BYTES = 4.
  - WORD_BYTES = 4.
- Sub-module byte_to_word_packer: 2-bit byte index, 32-bit shift register, word_ready pulse. Instantiated once and shared by the LEN and DATA states.

Test Plan:
- Load L=3, words 32'h00500093, 32'h00100113, 32'h002081B3 -> three wen pulses at w_addr 0x0, 0x4, 0x8 with those exact w_data; then load_done=1, cpu_hold=0, word_count=3.
- Length L=0 -> DONE immediately after the 4th length byte; no wen ever asserted.
- Length L=4097 (IMEM_WORDS=4096) -> ERR after the 4th length byte; load_err=1, cpu_hold=1, no wen.
- L=2, 6 payload bytes sent, then silence for TIMEOUT_CYCLES (bench value 100) -> ERR; exactly one wen observed.
- load_start pulsed after 5 payload bytes, then a full L=1 frame of 32'hDEADBEEF -> single wen at w_addr 0x0, data 32'hDEADBEEF, load_done=1.
- With IMEM_BOOT_CHECKSUM_EN, L=1 frame 32'h11223344 with checksum 8'h44 -> DONE; the same frame with 8'h45 -> ERR, cpu_hold stays 1.
